// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - ALU control issue stage: decodes ALUOp/funct, registers ctrl, sequences multi-cycle multiply
module alu_op_issue #(
   parameter int MUL_LATENCY = 3,
   parameter int CNT_W       = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       valid_i,
   input  logic [3:0] aluop_i,
   input  logic [5:0] funct_i,
   input  logic       flush_i,
   output logic       ready_o,
   output logic       valid_o,
   output logic [4:0] ctrl_o,
   output logic       stall_o,
   output logic       illegal_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      MUL_WAIT = 2'd2
   } state_t;

   localparam logic [4:0]       CODE_MUL  = 5'd16;
   localparam logic [4:0]       CODE_ILL  = 5'd31;
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic             MUL_MULTI = (MUL_LATENCY > 1);

   state_t           state_q, state_nxt;
   logic [4:0]       ctrl_q, ctrl_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             valid_q, valid_nxt;
   logic             stall_q, stall_nxt;
   logic             ill_q, ill_nxt;
   logic [4:0]       dec_code;
   logic             dec_ill;
   logic             accept;

   always_comb begin
      dec_code = CODE_ILL;
      case (aluop_i)
         4'd0: begin
            case (funct_i)
               6'd32:   dec_code = 5'd0;
               6'd34:   dec_code = 5'd2;
               6'd36:   dec_code = 5'd3;
               6'd37:   dec_code = 5'd4;
               6'd42:   dec_code = 5'd5;
               6'd24:   dec_code = CODE_MUL;
               6'd2:    dec_code = 5'd11;
               6'd6:    dec_code = 5'd12;
               6'd8:    dec_code = 5'd15;
               default: dec_code = CODE_ILL;
            endcase
         end
         4'd1:    dec_code = 5'd1;
         4'd2:    dec_code = 5'd6;
         4'd3:    dec_code = 5'd7;
         4'd4:    dec_code = 5'd8;
         4'd5:    dec_code = 5'd9;
         4'd6:    dec_code = 5'd10;
         4'd7:    dec_code = 5'd13;
         4'd8:    dec_code = 5'd14;
         4'd9:    dec_code = 5'd15;
         4'd10:   dec_code = 5'd17;
         4'd11:   dec_code = 5'd18;
         default: dec_code = CODE_ILL;
      endcase
   end

   assign dec_ill = (dec_code == CODE_ILL);
   assign ready_o = (state_q != MUL_WAIT);
   assign accept  = valid_i & ready_o;

   // Flush beats accept; an unaccepted cycle leaves ctrl holding its last code.
   always_comb begin
      state_nxt = state_q;
      ctrl_nxt  = ctrl_q;
      cnt_nxt   = cnt_q;
      valid_nxt = 1'b0;
      stall_nxt = 1'b0;
      ill_nxt   = 1'b0;
      if (flush_i) begin
         state_nxt = IDLE;
         ctrl_nxt  = 5'd0;
         cnt_nxt   = '0;
      end else if (accept) begin
         ctrl_nxt = dec_code;
         if ((dec_code == CODE_MUL) && MUL_MULTI) begin
            state_nxt = MUL_WAIT;
            cnt_nxt   = CNT_LOAD;
            stall_nxt = 1'b1;
         end else begin
            state_nxt = ISSUE;
            valid_nxt = 1'b1;
            ill_nxt   = dec_ill;
         end
      end else begin
         case (state_q)
            MUL_WAIT: begin
               if (cnt_q == CNT_ONE) begin
                  state_nxt = ISSUE;
                  cnt_nxt   = '0;
                  valid_nxt = 1'b1;
               end else begin
                  cnt_nxt   = cnt_q - CNT_ONE;
                  stall_nxt = 1'b1;
               end
            end
            ISSUE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         ctrl_q  <= 5'd0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         stall_q <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         ctrl_q  <= ctrl_nxt;
         cnt_q   <= cnt_nxt;
         valid_q <= valid_nxt;
         stall_q <= stall_nxt;
         ill_q   <= ill_nxt;
      end
   end

   assign ctrl_o    = ctrl_q;
   assign valid_o   = valid_q;
   assign stall_o   = stall_q;
   assign illegal_o = ill_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - self-checking bench for alu_op_issue
module tb_alu_op_issue;

   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [3:0] aluop;
   logic [5:0] funct;
   logic       flush;
   logic       ready_o, valid_o, stall_o, illegal_o;
   logic [4:0] ctrl_o;

   int checks = 0;
   int errors = 0;

   int funct_tab[64];
   int op_tab[16];

   logic       m_valid, m_stall, m_ill, m_ready;
   logic [4:0] m_ctrl;
   int         m_hold;

   alu_op_issue #(.MUL_LATENCY(LAT), .CNT_W(4)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .valid_i  (valid),
      .aluop_i  (aluop),
      .funct_i  (funct),
      .flush_i  (flush),
      .ready_o  (ready_o),
      .valid_o  (valid_o),
      .ctrl_o   (ctrl_o),
      .stall_o  (stall_o),
      .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   function automatic int ref_code(input int op, input int fn);
      if (op == 0) return funct_tab[fn];
      return op_tab[op];
   endfunction

   // Behavioural model: a mul keeps the unit busy for LAT cycles, everything else issues next cycle.
   task automatic model_step();
      int c;
      if (!rst || flush) begin
         m_valid = 0; m_ctrl = 0; m_stall = 0; m_ill = 0; m_ready = 1; m_hold = 0;
      end else if (valid && m_ready) begin
         c = ref_code(int'(aluop), int'(funct));
         m_ctrl = c[4:0];
         if (c == 16 && LAT > 1) begin
            m_hold = LAT - 1; m_valid = 0; m_stall = 1; m_ready = 0; m_ill = 0;
         end else begin
            m_valid = 1; m_stall = 0; m_ready = 1; m_ill = (c == 31);
         end
      end else if (m_hold > 0) begin
         m_hold--;
         if (m_hold == 0) begin
            m_valid = 1; m_stall = 0; m_ready = 1;
         end
      end else begin
         m_valid = 0; m_ill = 0; m_ready = 1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 0; valid = 1; aluop = 0; funct = 6'd32; flush = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({ctrl_o, valid_o, ready_o, stall_o, illegal_o} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_%0d: ctrl=%0d valid=%b ready=%b stall=%b ill=%b expected ctrl=0 valid=0 ready=1 stall=0 ill=0",
                     i, ctrl_o, valid_o, ready_o, stall_o, illegal_o);
         end
      end
      rst = 1;
      tick();
      checks++;
      if ({ctrl_o, valid_o} !== {5'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset_first_accept: ctrl=%0d valid=%b expected ctrl=0 valid=1", ctrl_o, valid_o);
      end
      valid = 0;
      tick();
   endtask

   task automatic test_decode_sweep();
      int sw_op[19]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 0, 0, 0, 0, 0, 0, 0};
      int sw_fn[19]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 34, 36, 37, 42, 2, 6, 8};
      int sw_exp[19] = '{1, 6, 7, 8, 9, 10, 13, 14, 15, 17, 18, 0, 2, 3, 4, 5, 11, 12, 15};
      for (int i = 0; i < 19; i++) begin
         valid = 1;
         aluop = 4'(sw_op[i]);
         funct = (sw_op[i] == 0) ? 6'(sw_fn[i]) : 6'($urandom_range(0, 63));
         tick();
         checks++;
         if ({ctrl_o, valid_o, stall_o, illegal_o} !== {5'(sw_exp[i]), 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL decode_%0d: ctrl=%0d valid=%b stall=%b ill=%b expected ctrl=%0d valid=1 stall=0 ill=0",
                     i, ctrl_o, valid_o, stall_o, illegal_o, sw_exp[i]);
         end
      end
      valid = 0;
      tick();
      checks++;
      if ({ctrl_o, valid_o} !== {5'd15, 1'b0}) begin
         errors++;
         $display("FAIL decode_hold: ctrl=%0d valid=%b expected ctrl=15 valid=0", ctrl_o, valid_o);
      end
   endtask

   task automatic test_multiply();
      logic exp_stall[3] = '{1'b1, 1'b1, 1'b0};
      logic exp_valid[3] = '{1'b0, 1'b0, 1'b1};
      logic exp_ready[3] = '{1'b0, 1'b0, 1'b1};
      valid = 1; aluop = 0; funct = 6'd24;
      tick();
      funct = 6'd32;
      for (int i = 0; i < LAT; i++) begin
         checks++;
         if ({ctrl_o, stall_o, valid_o, ready_o} !== {5'd16, exp_stall[i], exp_valid[i], exp_ready[i]}) begin
            errors++;
            $display("FAIL mul_cycle_%0d: ctrl=%0d stall=%b valid=%b ready=%b expected ctrl=16 stall=%b valid=%b ready=%b",
                     i, ctrl_o, stall_o, valid_o, ready_o, exp_stall[i], exp_valid[i], exp_ready[i]);
         end
         if (i < LAT - 1) tick();
      end
      tick();
      valid = 0;
      checks++;
      if ({ctrl_o, valid_o, stall_o} !== {5'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL mul_then_add: ctrl=%0d valid=%b stall=%b expected ctrl=0 valid=1 stall=0", ctrl_o, valid_o, stall_o);
      end
      tick();
   endtask

   task automatic test_flush();
      valid = 1; aluop = 0; funct = 6'd24;
      tick();
      valid = 0;
      tick();
      flush = 1;
      tick();
      flush = 0;
      checks++;
      if ({ctrl_o, valid_o, stall_o, ready_o, illegal_o} !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL flush_mid_mul: ctrl=%0d valid=%b stall=%b ready=%b ill=%b expected ctrl=0 valid=0 stall=0 ready=1 ill=0",
                  ctrl_o, valid_o, stall_o, ready_o, illegal_o);
      end
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_issue: valid=%b expected 0", valid_o);
      end
   endtask

   task automatic test_illegal();
      valid = 1; aluop = 0; funct = 6'd63;
      tick();
      checks++;
      if ({ctrl_o, illegal_o, valid_o} !== {5'd31, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL illegal_funct: ctrl=%0d ill=%b valid=%b expected ctrl=31 ill=1 valid=1", ctrl_o, illegal_o, valid_o);
      end
      aluop = 4'd13;
      tick();
      checks++;
      if ({ctrl_o, illegal_o, valid_o} !== {5'd31, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL illegal_aluop: ctrl=%0d ill=%b valid=%b expected ctrl=31 ill=1 valid=1", ctrl_o, illegal_o, valid_o);
      end
      valid = 0;
      tick();
      checks++;
      if ({illegal_o, valid_o} !== {1'b0, 1'b0}) begin
         errors++;
         $display("FAIL illegal_pulse: ill=%b valid=%b expected ill=0 valid=0", illegal_o, valid_o);
      end
   endtask

   task automatic test_reset_mid_mul();
      valid = 1; aluop = 0; funct = 6'd24;
      tick();
      valid = 0;
      rst = 0;
      tick();
      rst = 1;
      checks++;
      if ({ctrl_o, valid_o, stall_o, ready_o, illegal_o} !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_mul: ctrl=%0d valid=%b stall=%b ready=%b ill=%b expected ctrl=0 valid=0 stall=0 ready=1 ill=0",
                  ctrl_o, valid_o, stall_o, ready_o, illegal_o);
      end
      for (int i = 0; i < LAT; i++) begin
         tick();
         checks++;
         if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_aborted_mul_%0d: valid=%b expected 0", i, valid_o);
         end
      end
   endtask

   task automatic test_random();
      int mul_fns[10] = '{32, 34, 36, 37, 42, 24, 2, 6, 8, 24};
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 49) != 0);
         flush = ($urandom_range(0, 19) == 0);
         valid = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0: begin aluop = 0; funct = 6'(mul_fns[$urandom_range(0, 9)]); end
            1: begin aluop = 4'($urandom_range(1, 15)); funct = 6'($urandom_range(0, 63)); end
            2: begin aluop = 0; funct = 6'd24; end
            default: begin aluop = 0; funct = 6'($urandom_range(0, 63)); end
         endcase
         tick();
         checks++;
         if ({ready_o, valid_o, ctrl_o, stall_o, illegal_o} !== {m_ready, m_valid, m_ctrl, m_stall, m_ill}) begin
            errors++;
            $display("FAIL random_%0d: ready=%b valid=%b ctrl=%0d stall=%b ill=%b expected ready=%b valid=%b ctrl=%0d stall=%b ill=%b",
                     i, ready_o, valid_o, ctrl_o, stall_o, illegal_o, m_ready, m_valid, m_ctrl, m_stall, m_ill);
         end
      end
      rst = 1; flush = 0; valid = 0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) funct_tab[i] = 31;
      funct_tab[32] = 0;  funct_tab[34] = 2;  funct_tab[36] = 3;
      funct_tab[37] = 4;  funct_tab[42] = 5;  funct_tab[24] = 16;
      funct_tab[2]  = 11; funct_tab[6]  = 12; funct_tab[8]  = 15;
      op_tab = '{0, 1, 6, 7, 8, 9, 10, 13, 14, 15, 17, 18, 31, 31, 31, 31};
      m_valid = 0; m_ctrl = 0; m_stall = 0; m_ill = 0; m_ready = 1; m_hold = 0;
      rst = 0; valid = 0; aluop = 0; funct = 0; flush = 0;

      test_reset();
      test_decode_sweep();
      test_multiply();
      test_flush();
      test_illegal();
      test_reset_mid_mul();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Producer side of the 5-bit ALU control interface: decodes main-decoder ALUOp plus R-type funct into the ALU's ctrl code.
- Registers the ctrl code for the EX stage.
- Sequences multi-cycle multiply (code 16): holds ctrl and stalls upstream until the product is valid.
- Sits between the ID/EX pipeline register and the ALU; drives stall into hazard logic.

Parameters:
- MUL_LATENCY, 3, cycles ctrl_o holds code 16 for a multiply (legal range 1..15).
- CNT_W, 4, width of the multiply cycle counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- valid_i  input  1  upstream offers an operation this cycle.
- aluop_i  input  4  main-decoder ALU operation class.
- funct_i  input  6  instruction funct field; used only when aluop_i=0.
- flush_i  input  1  discard current and in-flight operation.
- ready_o  output  1  block accepts an operation this cycle.
- valid_o  output  1  ctrl_o is final for the ALU this cycle.
- ctrl_o  output  5  ALU control code.
- stall_o  output  1  freeze IF/ID and ID/EX registers.
- illegal_o  output  1  accepted operation had no legal encoding; pulses with valid_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_i; sampled only at the clk_i edge.
- Reset values: state=IDLE, ctrl_o=0, valid_o=0, stall_o=0, illegal_o=0, counter=0, ready_o=1.
- Accept: an operation is accepted when valid_i & ready_o at a clock edge.
  - ctrl_o and illegal_o are registered: they appear the cycle after acceptance (latency 1).
- Decode when aluop_i=0, by funct_i:
  - 32→0 (add), 34→2 (sub), 36→3 (and), 37→4 (or), 42→5 (slt).
  - 24→16 (mul), 2→11 (srl), 6→12 (srlv), 8→15 (jr).
  - Any other funct → 31 (ALU outputs 0) and illegal_o=1.
- Decode for other aluop_i values:
  - 1→1 (addi), 2→6 (slti), 3→7 (beq), 4→8 (bne), 5→9 (ori), 6→10 (lui).
  - 7→13 (lw), 8→14 (sw), 9→15 (j), 10→17 (bgez), 11→18 (bgt).
  - 12..15 → 31 with illegal_o=1.
- FSM states:
  - IDLE: no output. ready_o=1.
    - On accept of a non-mul op → ISSUE.
    - On accept of mul with MUL_LATENCY=1 → ISSUE.
    - On accept of mul otherwise → MUL_WAIT, counter=MUL_LATENCY-1.
  - ISSUE: valid_o=1 for exactly one cycle. ready_o=1, giving back-to-back single-cycle issue.
    - Accept this cycle → next op per the IDLE rules.
    - No accept → IDLE, with valid_o=0 and ctrl_o holding its last value.
  - MUL_WAIT: ctrl_o=16 held, valid_o=0, ready_o=0, stall_o=1.
    - Counter decrements each cycle.
    - When counter reaches 1 → ISSUE with ctrl_o=16, valid_o=1, stall_o=0.
    - A mul therefore occupies exactly MUL_LATENCY cycles with ctrl_o=16; stall_o is high for MUL_LATENCY-1 of them.
- stall_o: registered; high only in MUL_WAIT.
- flush_i:
  - Takes priority over accept and over the FSM.
  - Next cycle: state=IDLE, valid_o=0, stall_o=0, illegal_o=0, ctrl_o=0, counter=0.
  - valid_i in the same cycle is dropped.
- Reset mid-multiply: identical to flush; all outputs return to reset values at the next edge.
- valid_i while ready_o=0: ignored. Upstream must hold it; stall_o guarantees this.
- Counter width: CNT_W must hold MUL_LATENCY-1; no wrap occurs for the legal range.
- No combinational path from valid_i to valid_o. ready_o depends on state only.

Test Plan:
- Reset: rst_i=0 for 2 cycles with valid_i=1, aluop_i=0, funct_i=32 → ctrl_o=0, valid_o=0, ready_o=1 throughout; first accept after rst_i=1 gives ctrl_o=0, valid_o=1 one cycle later.
- Decode sweep: every aluop_i 1..11 and funct 32,34,36,37,42,2,6,8, each issued back-to-back → ctrl_o sequence 1,6,7,8,9,10,13,14,15,17,18,0,2,3,4,5,11,12,15; valid_o high every cycle; stall_o=0.
- Multiply, MUL_LATENCY=3: accept funct 24, then offer add → ctrl_o=16 for 3 cycles; stall_o=1,1,0; valid_o=0,0,1; ready_o low 2 cycles; add then issues ctrl_o=0.
- Flush mid-multiply: flush_i=1 in second MUL_WAIT cycle → next cycle ctrl_o=0, valid_o=0, stall_o=0, ready_o=1.
- Illegal: aluop_i=0, funct_i=63 and aluop_i=13 → ctrl_o=31, illegal_o=1 for one cycle each.
- Sync reset mid-multiply: rst_i=0 for one cycle during MUL_WAIT → reset values at the next edge; no valid_o pulse for the aborted mul.
